// File: rtl/rri_axil_reg_slave.sv
// AXI4-Lite slave for the four 32-bit rri_control registers (byte offsets 0x0..0xC).
// Exports the register contents and a one-cycle write strobe for each register.
module rri_axil_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [3:0]                      wr_pulse
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = DW / 8;

  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  logic            aw_held_reg, aw_held_next;
  logic            w_held_reg, w_held_next;
  logic            bvalid_reg, bvalid_next;
  logic            awready_reg, wready_reg, arready_reg;
  logic [1:0]      aw_idx_reg;
  logic [DW-1:0]   w_data_reg;
  logic [NB-1:0]   w_strb_reg;
  logic [3:0]      wr_pulse_reg;
  logic            aw_hs, w_hs, commit, ar_hs;
  rd_state_t       rd_state_reg, rd_state_next;
  logic [DW-1:0]   rdata_reg;
  logic            unused_bits;

  assign aw_hs  = S_AXI_AWVALID && awready_reg;
  assign w_hs   = S_AXI_WVALID && wready_reg;
  assign ar_hs  = S_AXI_ARVALID && arready_reg;
  assign commit = aw_held_reg && w_held_reg;

  always_comb begin
    aw_held_next = aw_held_reg;
    w_held_next  = w_held_reg;
    bvalid_next  = bvalid_reg;
    if (aw_hs) aw_held_next = 1'b1;
    if (w_hs)  w_held_next  = 1'b1;
    if (bvalid_reg && S_AXI_BREADY) bvalid_next = 1'b0;
    if (commit) begin
      aw_held_next = 1'b0;
      w_held_next  = 1'b0;
      bvalid_next  = 1'b1;
    end
  end

  // Ready flags are registered copies of the next-cycle acceptance condition.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_held_reg  <= 1'b0;
      w_held_reg   <= 1'b0;
      bvalid_reg   <= 1'b0;
      awready_reg  <= 1'b0;
      wready_reg   <= 1'b0;
      aw_idx_reg   <= '0;
      w_data_reg   <= '0;
      w_strb_reg   <= '0;
      wr_pulse_reg <= '0;
    end else begin
      aw_held_reg  <= aw_held_next;
      w_held_reg   <= w_held_next;
      bvalid_reg   <= bvalid_next;
      awready_reg  <= !aw_held_next && !bvalid_next;
      wready_reg   <= !w_held_next && !bvalid_next;
      if (aw_hs) aw_idx_reg <= S_AXI_AWADDR[3:2];
      if (w_hs) begin
        w_data_reg <= S_AXI_WDATA;
        w_strb_reg <= S_AXI_WSTRB;
      end
      wr_pulse_reg <= commit ? (4'b0001 << aw_idx_reg) : 4'b0000;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_reg
    logic [DW-1:0] q_reg;
    always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
        q_reg <= '0;
      end else if (commit && aw_idx_reg == 2'(gi)) begin
        for (int b = 0; b < NB; b++) begin
          if (w_strb_reg[b]) q_reg[8*b +: 8] <= w_data_reg[8*b +: 8];
        end
      end
    end
    assign reg_out[gi*DW +: DW] = q_reg;
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    case (rd_state_reg)
      R_IDLE:  if (ar_hs) rd_state_next = R_DATA;
      R_DATA:  if (S_AXI_RREADY) rd_state_next = R_IDLE;
      default: rd_state_next = R_IDLE;
    endcase
  end

  // RDATA samples reg_out before any same-edge commit lands, giving the pre-write value.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rd_state_reg <= R_IDLE;
      arready_reg  <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      rd_state_reg <= rd_state_next;
      arready_reg  <= (rd_state_next == R_IDLE);
      if (ar_hs) rdata_reg <= reg_out[S_AXI_ARADDR[3:2]*DW +: DW];
    end
  end

  assign S_AXI_AWREADY = awready_reg;
  assign S_AXI_WREADY  = wready_reg;
  assign S_AXI_BVALID  = bvalid_reg;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_reg;
  assign S_AXI_RVALID  = (rd_state_reg == R_DATA);
  assign S_AXI_RDATA   = rdata_reg;
  assign S_AXI_RRESP   = 2'b00;
  assign wr_pulse      = wr_pulse_reg;

  // Protection bits and the address bits outside [3:2] carry no meaning here.
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

endmodule

// File: tb/tb_rri_axil_reg_slave.sv
// Directed bench for rri_axil_reg_slave: scoreboard queues of expected read data
// and write strobes, checked with immediate assertions when the DUT responds.
module tb_rri_axil_reg_slave;

  logic         clk = 1'b0;
  logic         arst;
  logic [3:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb, wr_pulse;
  logic [1:0]   bresp, rresp;
  logic [127:0] reg_out;

  int           checks = 0;
  int           failures = 0;
  logic [31:0]  exp_regs [4];
  logic [31:0]  exp_rd_q [$];
  logic [3:0]   exp_wp_q [$];

  always #5 clk = ~clk;

  rri_axil_reg_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(arst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .wr_pulse(wr_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // AW is offered after aw_dly cycles and W after w_dly cycles; hold_b leaves BREADY low.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input bit hold_b);
    logic aw_done = 1'b0, w_done = 1'b0, aw_rdy, w_rdy, bv_early = 1'b0;
    int   cyc = 0, bcnt = 0;
    exp_wp_q.push_back(4'b0001 << addr[3:2]);
    for (int b = 0; b < 4; b++)
      if (strb[b]) exp_regs[addr[3:2]][8*b +: 8] = data[8*b +: 8];
    awaddr = addr; wdata = data; wstrb = strb; bready = !hold_b;
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      aw_rdy = awready; w_rdy = wready;
      bv_early |= bvalid;
      tick();
      if (awvalid && aw_rdy) aw_done = 1'b1;
      if (wvalid && w_rdy) w_done = 1'b1;
      cyc++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_handshakes_done", {30'd0, aw_done, w_done}, 32'd3);
    chk("wr_no_early_bvalid", {31'd0, bv_early}, 32'd0);
    while (!bvalid && bcnt < 20) begin
      tick();
      bcnt++;
    end
    chk("wr_bvalid_latency", bcnt, 1);
    chk("wr_pulse", {28'd0, wr_pulse}, {28'd0, exp_wp_q.pop_front()});
    chk("wr_bresp", {30'd0, bresp}, 32'd0);
    chk("wr_reg_out", reg_out[addr[3:2]*32 +: 32], exp_regs[addr[3:2]]);
    if (!hold_b) begin
      tick();
      chk("wr_b_done", {28'd0, bvalid, wr_pulse[2:0]}, 32'd0);
      chk("wr_ready_back", {30'd0, awready, wready}, 32'd3);
      bready = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [3:0] addr, input bit hold_r);
    logic ar_rdy;
    logic ar_done = 1'b0;
    int   cyc = 0;
    exp_rd_q.push_back(exp_regs[addr[3:2]]);
    araddr = addr; arvalid = 1'b1; rready = !hold_r;
    while (!ar_done && cyc < 50) begin
      ar_rdy = arready;
      tick();
      ar_done = ar_rdy;
      cyc++;
    end
    arvalid = 1'b0;
    chk("rd_ar_done", {31'd0, ar_done}, 32'd1);
    chk("rd_rvalid_latency", {31'd0, rvalid}, 32'd1);
    chk("rd_rdata", rdata, exp_rd_q.pop_front());
    chk("rd_rresp", {30'd0, rresp}, 32'd0);
    if (!hold_r) begin
      tick();
      chk("rd_done", {30'd0, rvalid, arready}, 32'd1);
      rready = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] held_rdata;
    arst = 1'b1; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = '0;
    for (int i = 0; i < 4; i++) exp_regs[i] = '0;

    // Reset state
    tick(); tick();
    chk("rst_readies", {29'd0, awready, wready, arready}, 32'd0);
    chk("rst_valids", {30'd0, bvalid, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_reg_out_or", {31'd0, |reg_out}, 32'd0);
    chk("rst_misc", {24'd0, wr_pulse, bresp, rresp}, 32'd0);
    arst = 1'b0;
    tick();
    chk("post_rst_readies", {29'd0, awready, wready, arready}, 32'd7);

    // Sequential writes then reads
    for (int i = 0; i < 4; i++) axi_write(4'(i*4), 32'(i+1), 4'hF, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) axi_read(4'(i*4), 1'b0);

    // W ahead of AW, then AW ahead of W
    axi_write(4'h8, 32'hA5A5A5A5, 4'hF, 3, 0, 1'b0);
    axi_read(4'h8, 1'b0);
    axi_write(4'h8, 32'h0F0F1234, 4'hF, 0, 2, 1'b0);
    axi_read(4'h8, 1'b0);

    // Byte strobes, including an all-zero strobe
    axi_write(4'h4, 32'hFFFFFFFF, 4'hF, 0, 0, 1'b0);
    axi_write(4'h4, 32'h12345678, 4'b0101, 0, 0, 1'b0);
    axi_read(4'h4, 1'b0);
    chk("strb_value", exp_regs[1], 32'hFF34FF78);
    axi_write(4'hC, 32'hDEADBEEF, 4'h0, 0, 0, 1'b0);
    axi_read(4'hF, 1'b0);

    // B back-pressure: a second AW must not be taken while BVALID is high
    axi_write(4'h0, 32'hCAFEF00D, 4'hF, 0, 0, 1'b1);
    awaddr = 4'h4; awvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bhold_state", {29'd0, bvalid, awready, wready}, 32'd4);
    end
    bready = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("bhold_release", {30'd0, bvalid, awready}, 32'd1);
    bready = 1'b0;
    axi_read(4'h4, 1'b0);

    // R back-pressure: RDATA stable, a second AR not taken
    axi_read(4'h0, 1'b1);
    held_rdata = exp_regs[0];
    araddr = 4'h8; arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rhold_rdata", rdata, held_rdata);
      chk("rhold_flags", {30'd0, rvalid, arready}, 32'd2);
    end
    arvalid = 1'b0; rready = 1'b1;
    tick();
    chk("rhold_release", {30'd0, rvalid, arready}, 32'd1);
    rready = 1'b0;

    // Reset while AW is held and W is pending
    awaddr = 4'h8; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1'b1; arst = 1'b1;
    tick();
    chk("midrst_outputs", {27'd0, bvalid, rvalid, awready, wready, arready}, 32'd0);
    chk("midrst_reg_out_or", {31'd0, |reg_out}, 32'd0);
    arst = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 4; i++) exp_regs[i] = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst_no_b", {27'd0, bvalid, wr_pulse}, 32'd0);
    end
    for (int i = 0; i < 4; i++) axi_read(4'(i*4), 1'b0);
    axi_write(4'h0, 32'h0000005A, 4'hF, 0, 0, 1'b0);
    axi_read(4'h0, 1'b0);
    axi_read(4'h8, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
